// File: rtl/systolic_skew_sched_if.sv
// Scheduler <-> activation buffer / systolic array boundary.
// Groups the buffer read port and the skewed lane outputs into one bundle.
interface systolic_skew_sched_if #(
  parameter int DATA_SIZE = 8,
  parameter int ARRAY_DIM = 4,
  parameter int ADDR_W    = 8
);
  // Handshake: the array raises array_ready to accept one lane step. When it is
  // low nothing moves: no read is issued and every lane output holds its value.
  // rd_data answers rd_en one cycle later and the buffer keeps it until the next rd_en.
  logic                           array_ready;
  logic                           rd_en;
  logic [ADDR_W-1:0]              rd_addr;
  logic [DATA_SIZE*ARRAY_DIM-1:0] rd_data;
  logic [DATA_SIZE*ARRAY_DIM-1:0] lane_data;
  logic [ARRAY_DIM-1:0]           lane_valid;
  logic [ARRAY_DIM-1:0]           lane_last;

  modport master (
    input  array_ready, rd_data,
    output rd_en, rd_addr, lane_data, lane_valid, lane_last
  );

  modport slave (
    output array_ready, rd_data,
    input  rd_en, rd_addr, lane_data, lane_valid, lane_last
  );
endinterface

// File: rtl/systolic_skew_sched.sv
// Streams K column vectors from the activation buffer into the array's row inputs,
// delaying lane i by i cycles (diagonal skew) and honouring array back-pressure.
module systolic_skew_sched #(
  parameter int DATA_SIZE = 8,
  parameter int ARRAY_DIM = 4,
  parameter int ADDR_W    = 8,
  parameter int K_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state,
  systolic_skew_sched_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [K_W-1:0]                 k_q, k_d;
  logic [K_W-1:0]                 klen_q, klen_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic                           zdone_q, zdone_d;
  logic                           pend_v_q, pend_v_d;
  logic                           pend_l_q, pend_l_d;
  logic [DATA_SIZE*ARRAY_DIM-1:0] cap_data_q, cap_data_d;
  logic [ARRAY_DIM-1:0]           vchain_q, vchain_d;
  logic [ARRAY_DIM-1:0]           lchain_q, lchain_d;

  logic                           rd_en;
  logic                           drain_done;
  logic                           last_k;
  logic [DATA_SIZE-1:0]           lane_elem [ARRAY_DIM];
  logic [DATA_SIZE*ARRAY_DIM-1:0] lane_data_w;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    klen_d     = klen_q;
    base_d     = base_q;
    zdone_d    = 1'b0;
    pend_v_d   = pend_v_q;
    pend_l_d   = pend_l_q;
    cap_data_d = cap_data_q;
    vchain_d   = vchain_q;
    lchain_d   = lchain_q;
    rd_en      = 1'b0;
    drain_done = 1'b0;
    last_k     = (k_q == klen_q - K_W'(1));

    case (state_q)
      IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            klen_d  = k_len;
            base_d  = base_addr;
            k_d     = '0;
            state_d = FETCH;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (bus.array_ready) begin
          rd_en = 1'b1;
          k_d   = k_q + K_W'(1);
          if (last_k) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.array_ready && !pend_v_q && (vchain_q == '0)) begin
          state_d    = IDLE;
          drain_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every pipeline stage advances only on an accepted lane step.
    // Invalid capture slots load zero so padding propagates down the delay lines.
    if (bus.array_ready) begin
      pend_v_d   = rd_en;
      pend_l_d   = rd_en && last_k;
      cap_data_d = pend_v_q ? bus.rd_data : '0;
      vchain_d   = {vchain_q[ARRAY_DIM-2:0], pend_v_q};
      lchain_d   = {lchain_q[ARRAY_DIM-2:0], pend_l_q};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      klen_q     <= '0;
      base_q     <= '0;
      zdone_q    <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_l_q   <= 1'b0;
      cap_data_q <= '0;
      vchain_q   <= '0;
      lchain_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      klen_q     <= klen_d;
      base_q     <= base_d;
      zdone_q    <= zdone_d;
      pend_v_q   <= pend_v_d;
      pend_l_q   <= pend_l_d;
      cap_data_q <= cap_data_d;
      vchain_q   <= vchain_d;
      lchain_q   <= lchain_d;
    end
  end

  assign lane_elem[0] = cap_data_q[DATA_SIZE-1:0];

  // Lane i carries only its own element through i extra registers.
  for (genvar i = 1; i < ARRAY_DIM; i++) begin : g_lane
    logic [DATA_SIZE-1:0] dly_q [i];
    logic [DATA_SIZE-1:0] dly_d [i];

    always_comb begin
      dly_d = dly_q;
      if (bus.array_ready) begin
        dly_d[0] = cap_data_q[i*DATA_SIZE +: DATA_SIZE];
        for (int j = 1; j < i; j++) dly_d[j] = dly_q[j-1];
      end
    end

    always_ff @(posedge clock) begin
      if (reset) dly_q <= '{default: '0};
      else       dly_q <= dly_d;
    end

    assign lane_elem[i] = dly_q[i-1];
  end

  always_comb begin
    lane_data_w = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      lane_data_w[i*DATA_SIZE +: DATA_SIZE] = vchain_q[i] ? lane_elem[i] : '0;
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = (state_q == FETCH) ? base_q + ADDR_W'(k_q) : '0;
  assign bus.lane_data  = lane_data_w;
  assign bus.lane_valid = vchain_q;
  assign bus.lane_last  = lchain_q;
  assign done           = zdone_q | drain_done;
  assign busy           = (state_q != IDLE) && !drain_done;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_systolic_skew_sched.sv
// Bench for systolic_skew_sched: directed table plus randomized streams, each cycle
// compared against a timeline model derived from the count of accepted lane steps.
module tb_systolic_skew_sched;

  localparam int D  = 8;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int KW = 8;
  localparam int W  = 1 + AW + D*N + 2*N + 2;
  localparam int MAXC = 600;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  systolic_skew_sched_if #(.DATA_SIZE(D), .ARRAY_DIM(N), .ADDR_W(AW)) bus ();

  systolic_skew_sched #(.DATA_SIZE(D), .ARRAY_DIM(N), .ADDR_W(AW), .K_W(KW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- buffer model ----------------
  logic [D*N-1:0] mem [256];

  always @(posedge clock) begin
    if (reset)          bus.rd_data <= '0;
    else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  bit           rdy [MAXC];
  int           n_vec = 0;
  int           n_err = 0;

  typedef struct {
    int           k;
    logic [AW-1:0] base;
    logic [63:0]  stall;     // bit j: array_ready low in cycle F+j
    bit           poke;
    int           done_at;   // cycles from the start cycle to the done pulse
  } vec_t;

  vec_t tbl [4];

  function automatic logic [W-1:0] pack(input logic re, input logic [AW-1:0] ra,
                                        input logic [D*N-1:0] ld, input logic [N-1:0] lv,
                                        input logic [N-1:0] ll, input logic b, input logic d);
    return {re, ra, ld, lv, ll, b, d};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return pack(bus.rd_en, bus.rd_addr, bus.lane_data, bus.lane_valid, bus.lane_last, busy, done);
  endfunction

  // Expected trace from the start cycle onward. m counts accepted lane steps since
  // the first FETCH cycle; vector kk sits on lane i once m = kk + 2 + i.
  task automatic build_trace(input int k, input logic [AW-1:0] base);
    int m;
    exp_q.delete();
    exp_q.push_back('0);
    if (k == 0) begin
      exp_q.push_back(pack(1'b0, '0, '0, '0, '0, 1'b0, 1'b1));
      exp_q.push_back('0);
      return;
    end
    m = 0;
    for (int c = 0; c < MAXC; c++) begin
      logic           re, fin;
      logic [AW-1:0]  ra;
      logic [D*N-1:0] ld;
      logic [N-1:0]   lv, ll;
      re = rdy[c] && (m < k);
      ra = (m < k) ? base + AW'(m) : '0;
      ld = '0; lv = '0; ll = '0;
      for (int i = 0; i < N; i++) begin
        int kk;
        logic [AW-1:0] a;
        kk = m - 2 - i;
        if (kk >= 0 && kk < k) begin
          a = base + AW'(kk);
          lv[i] = 1'b1;
          ll[i] = (kk == k - 1);
          ld[i*D +: D] = mem[a][i*D +: D];
        end
      end
      fin = rdy[c] && (m == k + N + 1);
      exp_q.push_back(pack(re, ra, ld, lv, ll, !fin, fin));
      if (fin) break;
      if (rdy[c]) m++;
    end
    exp_q.push_back('0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; start = 1'b1; k_len = 8'd3; base_addr = 8'h40; bus.array_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if (dut_word() !== '0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got=%h/%0d exp=0/0", dut_word(), dbg_state);
    end
    @(posedge clock); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    n_vec++;
    if (dbg_state !== 2'd0 || busy !== 1'b0 || bus.rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_beats_start state=%0d busy=%b rd_en=%b exp 0/0/0", dbg_state, busy, bus.rd_en);
    end
  endtask

  task automatic run_stream(input int k, input logic [AW-1:0] base, input logic [63:0] stall,
                            input bit poke, output int done_at);
    logic [AW-1:0] addrs[$];
    logic [W-1:0]  exp_w, got_w;
    int            cyc;
    bit            addr_ok;
    for (int j = 0; j < MAXC; j++) rdy[j] = (j < 64) ? !stall[j] : 1'b1;
    build_trace(k, base);
    done_at = -1;
    @(posedge clock); #1;
    start = 1'b1; k_len = KW'(k); base_addr = base; bus.array_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      exp_w = exp_q.pop_front();
      got_w = dut_word();
      n_vec++;
      if (got_w !== exp_w) begin
        n_err++;
        $display("FAIL trace k=%0d base=%h cyc=%0d got=%h exp=%h", k, base, cyc, got_w, exp_w);
      end
      if (done === 1'b1 && done_at < 0) done_at = cyc;
      if (bus.rd_en === 1'b1) addrs.push_back(bus.rd_addr);
      @(posedge clock); #1;
      if (poke && k > 0 && cyc == 3) begin
        start = 1'b1; k_len = KW'($urandom_range(1, 255)); base_addr = AW'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      bus.array_ready = rdy[cyc];
      cyc++;
    end
    start = 1'b0; bus.array_ready = 1'b1;
    addr_ok = (addrs.size() == k);
    for (int j = 0; j < addrs.size(); j++) if (addrs[j] !== base + AW'(j)) addr_ok = 1'b0;
    n_vec++;
    if (!addr_ok) begin
      n_err++;
      $display("FAIL rd_addr_seq base=%h issued=%0d exp_count=%0d", base, addrs.size(), k);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int dat;
    reset = 1'b1; start = 1'b0; k_len = '0; base_addr = '0; bus.array_ready = 1'b1;
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < N; i++) mem[a][i*D +: D] = D'((a - 16) * 4 + i);

    tbl[0] = '{k: 3, base: 8'h10, stall: 64'h0,  poke: 1'b0, done_at: 9};
    tbl[1] = '{k: 3, base: 8'h10, stall: 64'h22, poke: 1'b0, done_at: 11};
    tbl[2] = '{k: 4, base: 8'hFE, stall: 64'h0,  poke: 1'b0, done_at: 10};
    tbl[3] = '{k: 0, base: 8'h33, stall: 64'h0,  poke: 1'b0, done_at: 1};

    do_reset();

    for (int t = 0; t < 4; t++) begin
      run_stream(tbl[t].k, tbl[t].base, tbl[t].stall, tbl[t].poke, dat);
      n_vec++;
      if (dat != tbl[t].done_at) begin
        n_err++;
        $display("FAIL done_latency vec=%0d got=%0d exp=%0d", t, dat, tbl[t].done_at);
      end
    end

    // start while busy must not disturb the running stream
    run_stream(3, 8'h10, 64'h0, 1'b1, dat);
    n_vec++;
    if (dat != 9) begin
      n_err++;
      $display("FAIL start_while_busy got=%0d exp=9", dat);
    end

    // reset in the FETCH cycle issuing k=1
    @(posedge clock); #1;
    start = 1'b1; k_len = 8'd5; base_addr = 8'h20; bus.array_ready = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (dut_word() !== '0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL abort_state got=%h/%0d exp=0/0", dut_word(), dbg_state);
    end
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (10) begin
        @(negedge clock);
        if (done !== 1'b0 || bus.rd_en !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
      end
      n_vec++;
      if (!quiet) begin
        n_err++;
        $display("FAIL abort_quiet got=activity exp=idle");
      end
    end
    run_stream(tbl[0].k, tbl[0].base, tbl[0].stall, 1'b0, dat);
    n_vec++;
    if (dat != tbl[0].done_at) begin
      n_err++;
      $display("FAIL restart_latency got=%0d exp=%0d", dat, tbl[0].done_at);
    end

    // randomized streams
    for (int a = 0; a < 256; a++) mem[a] = (D*N)'($urandom());
    for (int r = 0; r < 24; r++) begin
      logic [63:0] sm;
      for (int j = 0; j < 64; j++) sm[j] = ($urandom_range(0, 3) == 0);
      run_stream($urandom_range(1, 20), AW'($urandom_range(0, 255)), sm,
                 bit'($urandom_range(0, 1)), dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
